// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
//   Host/receiver-side signal bundle for uart_rx_fifo.
//   master : drives Rx_Data, Data_Rdy, Read_Done, BIST_Mode, Clr_Overflow
//            (receiver strobes plus host read/control); observes the outputs.
//   slave  : the FIFO; drives Data_Out, Data_Valid, FIFO_Empty, FIFO_Full,
//            FIFO_Almost_Full, FIFO_Overflow, FIFO_Count.
interface uart_rx_fifo_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [DATA_BITS-1:0] Rx_Data;
   logic                 Data_Rdy;
   logic                 Read_Done;
   logic                 BIST_Mode;
   logic                 Clr_Overflow;
   logic [DATA_BITS-1:0] Data_Out;
   logic                 Data_Valid;
   logic                 FIFO_Empty;
   logic                 FIFO_Full;
   logic                 FIFO_Almost_Full;
   logic                 FIFO_Overflow;
   logic [CW-1:0]        FIFO_Count;

   modport master (
      output Rx_Data, Data_Rdy, Read_Done, BIST_Mode, Clr_Overflow,
      input  Data_Out, Data_Valid, FIFO_Empty, FIFO_Full,
             FIFO_Almost_Full, FIFO_Overflow, FIFO_Count
   );

   modport slave (
      input  Rx_Data, Data_Rdy, Read_Done, BIST_Mode, Clr_Overflow,
      output Data_Out, Data_Valid, FIFO_Empty, FIFO_Full,
             FIFO_Almost_Full, FIFO_Overflow, FIFO_Count
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Single-clock circular receive FIFO between the UART receiver and the
//   host reader. Supports simultaneous read/write (including write on full
//   with a same-cycle pop), occupancy count, almost-full threshold and a
//   sticky overflow flag with explicit clear.
//   Optional macro UART_RX_FIFO_FWFT_EN selects first-word-fall-through
//   read mode; otherwise reads are registered (pop-then-present).
// Ports:
//   Clk  - clock, rising-edge
//   Rst  - synchronous active-high reset
//   bus  - uart_rx_fifo_if.slave (receiver strobes, host read, status)
module uart_rx_fifo #(
   parameter int DATA_BITS         = 8,
   parameter int FIFO_DEPTH        = 16,
   parameter int ALMOST_FULL_LEVEL = 12
) (
   input  logic          Clk,
   input  logic          Rst,
   uart_rx_fifo_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH) + 1;
   localparam int AW = PW - 1;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]        wptr;
   logic [PW-1:0]        rptr;
   logic [PW-1:0]        count;
   logic                 empty;
   logic                 full;
   logic                 rd_ok;
   logic                 wr_ok;
   logic                 drop;
   logic                 overflow;

   // Extra pointer bit distinguishes full from empty after wrap-around.
   assign count = wptr - rptr;
   assign empty = (count == '0);
   assign full  = (count == PW'(FIFO_DEPTH));

   assign rd_ok = bus.Read_Done && !empty;
   assign wr_ok = bus.Data_Rdy && !bus.BIST_Mode && (!full || rd_ok);
   assign drop  = bus.Data_Rdy && !bus.BIST_Mode && full && !rd_ok;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         wptr     <= '0;
         rptr     <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_ok) wptr <= wptr + 1'b1;
         if (rd_ok) rptr <= rptr + 1'b1;
         // Set takes priority over a same-cycle clear.
         if (drop)
            overflow <= 1'b1;
         else if (bus.Clr_Overflow)
            overflow <= 1'b0;
      end
   end

   // Storage is never cleared; reset only blocks the same-cycle write.
   always_ff @(posedge Clk) begin
      if (!Rst && wr_ok)
         mem[wptr[AW-1:0]] <= bus.Rx_Data;
   end

`ifdef UART_RX_FIFO_FWFT_EN
   always_comb begin
      bus.Data_Out   = '0;
      bus.Data_Valid = !empty;
      if (!empty)
         bus.Data_Out = mem[rptr[AW-1:0]];
   end
`else
   logic [DATA_BITS-1:0] dout;
   logic                 dvalid;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         dout   <= '0;
         dvalid <= 1'b0;
      end else begin
         dvalid <= rd_ok;
         if (rd_ok)
            dout <= mem[rptr[AW-1:0]];
      end
   end

   assign bus.Data_Out   = dout;
   assign bus.Data_Valid = dvalid;
`endif

   assign bus.FIFO_Empty       = empty;
   assign bus.FIFO_Full        = full;
   assign bus.FIFO_Almost_Full = (count >= PW'(ALMOST_FULL_LEVEL));
   assign bus.FIFO_Overflow    = overflow;
   assign bus.FIFO_Count       = count;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Directed and randomized stimulus for uart_rx_fifo, checked every cycle
//   against a queue-based reference model. Mode follows UART_RX_FIFO_FWFT_EN.
module tb_uart_rx_fifo;
   localparam int W  = 8;
   localparam int D  = 16;
   localparam int AF = 12;

   logic Clk = 1'b0;
   logic Rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   // Reference model state
   logic [W-1:0] q[$];
   logic         m_ovf;
   logic [W-1:0] m_dout;
   logic         m_dv;

   uart_rx_fifo_if #(.DATA_BITS(W), .FIFO_DEPTH(D)) bus ();

   uart_rx_fifo #(.DATA_BITS(W), .FIFO_DEPTH(D), .ALMOST_FULL_LEVEL(AF)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      int n;
      n = q.size();
      check("count", 32'(bus.FIFO_Count), n);
      check("empty", 32'(bus.FIFO_Empty), (n == 0) ? 1 : 0);
      check("full", 32'(bus.FIFO_Full), (n == D) ? 1 : 0);
      check("almost_full", 32'(bus.FIFO_Almost_Full), (n >= AF) ? 1 : 0);
      check("overflow", 32'(bus.FIFO_Overflow), 32'(m_ovf));
`ifdef UART_RX_FIFO_FWFT_EN
      check("data_out", 32'(bus.Data_Out), (n > 0) ? 32'(q[0]) : 0);
      check("data_valid", 32'(bus.Data_Valid), (n > 0) ? 1 : 0);
`else
      check("data_out", 32'(bus.Data_Out), 32'(m_dout));
      check("data_valid", 32'(bus.Data_Valid), 32'(m_dv));
`endif
   endtask

   // One clock: drive at negedge, update model from the pre-edge state,
   // compare shortly after the rising edge.
   task automatic step(input logic wr, input logic [W-1:0] din, input logic rd,
                       input logic bist, input logic clr, input logic rst);
      logic rdok, wrok;
      @(negedge Clk);
      bus.Data_Rdy     = wr;
      bus.Rx_Data      = din;
      bus.Read_Done    = rd;
      bus.BIST_Mode    = bist;
      bus.Clr_Overflow = clr;
      Rst              = rst;
      @(posedge Clk);
      #1;
      if (rst) begin
         q.delete();
         m_ovf  = 1'b0;
         m_dout = '0;
         m_dv   = 1'b0;
      end else begin
         rdok = rd && (q.size() > 0);
         wrok = wr && !bist && ((q.size() < D) || rdok);
         m_dv = rdok;
         if (rdok) m_dout = q.pop_front();
         if (wrok) q.push_back(din);
         if (wr && !bist && !wrok) m_ovf = 1'b1;
         else if (clr) m_ovf = 1'b0;
      end
      check_all();
   endtask

   initial begin
      logic [W-1:0] d;
      bus.Data_Rdy     = 1'b0;
      bus.Rx_Data      = '0;
      bus.Read_Done    = 1'b0;
      bus.BIST_Mode    = 1'b0;
      bus.Clr_Overflow = 1'b0;

      // Reset state
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);

      // Fill 0x01..0x10; flags checked every cycle
      for (int i = 1; i <= D; i++) step(1, W'(i), 0, 0, 0, 0);
      check("full_after_fill", 32'(bus.FIFO_Full), 1);

      // Write on full without pop -> dropped, overflow sticky
      step(1, 8'hAA, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < D; i++) step(0, 0, 1, 0, 0, 0);
      check("ovf_kept_after_drain", 32'(bus.FIFO_Overflow), 1);
      step(0, 0, 0, 0, 1, 0);

      // Full with simultaneous pop+write of 0x55
      for (int i = 1; i <= D; i++) step(1, W'(i), 0, 0, 0, 0);
      step(1, 8'h55, 1, 0, 0, 0);
      for (int i = 0; i < D; i++) step(0, 0, 1, 0, 0, 0);
      check("last_drained_55", 32'(bus.Data_Out), 32'h55);

      // Overflow set and clear in the same cycle: set wins
      for (int i = 0; i < D; i++) step(1, W'($urandom), 0, 0, 0, 0);
      step(1, 8'hEE, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < D; i++) step(0, 0, 1, 0, 0, 0);

      // Wrap-around: 40 write/pop pairs
      d = W'($urandom);
      for (int i = 0; i < 40; i++) begin
         step(1, d, 0, 0, 0, 0);
         step(0, 0, 1, 0, 0, 0);
         d = d + 1'b1;
      end

      // BIST blocks writes; read on empty ignored
      for (int i = 0; i < 20; i++) step(1, 8'h33, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0);

      // Randomized mix
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 99) < 60), W'($urandom), ($urandom_range(0, 99) < 45),
              ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 5), 1'b0);

      // Mid-stream reset with same-cycle write
      step(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(1, W'($urandom), 0, 0, 0, 0);
      step(1, 8'h77, 1, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);
      check("empty_after_rst", 32'(bus.FIFO_Empty), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Synchronous, parametrised receive FIFO sitting between the UART receiver's `Data_Rdy`/`Rx_Data` output and the host-side reader. It replaces the strobe-clocked buffer with a single-clock circular buffer. Additions over that buffer:
- simultaneous read/write
- true full/empty detection with wrap-around
- occupancy count and almost-full threshold
- sticky overflow with explicit clear
- optional first-word-fall-through read mode

## Interface
- `DATA_BITS`, 8, width of each stored word.
- `FIFO_DEPTH`, 16, number of entries; power of two, ≥ 2.
- `ALMOST_FULL_LEVEL`, 12, occupancy at or above which `FIFO_Almost_Full` asserts; range 1..`FIFO_DEPTH`.

Ports:
- `Clk` input 1 — single clock; all state updates on the rising edge.
- `Rst` input 1 — reset is synchronous and active-high.
- `Rx_Data` input `DATA_BITS` — word from the receiver.
- `Data_Rdy` input 1 — write strobe, one cycle per word.
- `Read_Done` input 1 — read/pop strobe, one cycle per word.
- `BIST_Mode` input 1 — blocks writes while high.
- `Clr_Overflow` input 1 — clears sticky overflow.
- `Data_Out` output `DATA_BITS` — read data.
- `Data_Valid` output 1 — `Data_Out` holds a popped/head word.
- `FIFO_Empty` output 1 — occupancy == 0.
- `FIFO_Full` output 1 — occupancy == `FIFO_DEPTH`.
- `FIFO_Almost_Full` output 1 — occupancy ≥ `ALMOST_FULL_LEVEL`.
- `FIFO_Overflow` output 1 — sticky; a write was dropped.
- `FIFO_Count` output $clog2(`FIFO_DEPTH`)+1 — current occupancy.

## Operation
- Storage is a `FIFO_DEPTH` x `DATA_BITS` array. Write and read pointers are $clog2(`FIFO_DEPTH`)+1 bits wide, and the low bits index the array.
- Pointers wrap naturally modulo 2·`FIFO_DEPTH`. `FIFO_Count` = wptr − rptr, modulo the pointer width.
- Read accept is `rd_ok` = `Read_Done` && !`FIFO_Empty`. On accept, rptr increments.
- Write accept is `wr_ok` = `Data_Rdy` && !`BIST_Mode` && (!`FIFO_Full` || `rd_ok`). On accept, `Rx_Data` is stored at wptr and wptr increments.
- Simultaneous `wr_ok` and `rd_ok`: both pointers advance and the count is unchanged. This holds when full, so a write on a full FIFO with a same-cycle pop is accepted.
- When full, with `Data_Rdy` high, `BIST_Mode` low and no `rd_ok`: the word is dropped, the array and pointers are unchanged, and `FIFO_Overflow` is set.
- `Read_Done` on empty is ignored: pointers unchanged, `Data_Out` holds, no error flag.
- `BIST_Mode` high: `Data_Rdy` is fully ignored (no store, no overflow). Reads still operate.
- `FIFO_Overflow` is sticky and is cleared by `Clr_Overflow` or `Rst`. If a set event and `Clr_Overflow` occur in the same cycle, set wins.
- `FIFO_Empty`, `FIFO_Full`, `FIFO_Almost_Full` and `FIFO_Count` are decoded from the registered pointers only.
- Default (non-FWFT) read: on `rd_ok`, `Data_Out` <= array[rptr] and `Data_Valid` pulses high for exactly one cycle. Otherwise `Data_Out` holds and `Data_Valid` = 0.

## Timing
- Reset values:
  - `Data_Out` = 0, `Data_Valid` = 0, `FIFO_Empty` = 1
  - `FIFO_Full` = 0, `FIFO_Almost_Full` = 0, `FIFO_Overflow` = 0, `FIFO_Count` = 0
  - both pointers = 0; array contents are not cleared
- `Rst` has priority over all strobes in the same cycle. A mid-stream reset discards all entries, and the next cycle starts empty.
- Write-to-flag latency is 1 cycle: flags and count reflect a write from the cycle after the accepting edge.
- Write-to-read latency is 1 cycle: a word written at edge N can be popped by `Read_Done` sampled at edge N+1.
- Non-FWFT read latency is 1 cycle: `Read_Done` sampled at edge N gives `Data_Out`/`Data_Valid` valid after edge N.
- Back-to-back strobes on consecutive cycles are supported at full rate for both read and write.

## Configuration
- Macro: `UART_RX_FIFO_FWFT_EN`.
- Defined (first-word-fall-through):
  - `Data_Out` = array[rptr] whenever !`FIFO_Empty`, and `Data_Out` = 0 when empty.
  - `Data_Valid` = !`FIFO_Empty`.
  - `Read_Done` acknowledges the displayed word and advances to the next. The new head is visible the cycle after the pop.
  - A word written into an empty FIFO appears on `Data_Out` the cycle after the write edge.
- Undefined: registered pop-then-present behaviour as in Operation. The pointer, flag and overflow logic is identical in both modes.

## Test plan
- Write 0x01..0x10 (16 words) at defaults -> `FIFO_Count` steps 1..16. `FIFO_Almost_Full` asserts the cycle after the 12th write, `FIFO_Full` after the 16th, `FIFO_Overflow` stays 0.
- Full FIFO, write 0xAA with no read -> count stays 16, `FIFO_Overflow` = 1, and the subsequent 16 pops return 0x01..0x10 (0xAA absent). Then pulse `Clr_Overflow` -> `FIFO_Overflow` = 0.
- Full FIFO, `Data_Rdy` = `Read_Done` = 1 with 0x55 -> pop returns 0x01, count stays 16, no overflow, and 0x55 is the last word drained.
- Wrap-around: 40 interleaved write/pop pairs with incrementing data -> data returned in order, count never exceeds 1, `FIFO_Empty` = 1 at end.
- `BIST_Mode` = 1, 20 writes of 0x33 -> count stays 0, `FIFO_Overflow` = 0. Also, `Read_Done` on empty -> `Data_Valid` = 0 and `Data_Out` unchanged.
- Write 3 words, assert `Rst` with a same-cycle `Data_Rdy` -> next cycle count = 0, `FIFO_Empty` = 1, all outputs at reset values. Repeat the suite with `UART_RX_FIFO_FWFT_EN` defined, checking the head word is visible without a pop.
